// File: rtl/pipeline_stall_sequencer.sv
// pipeline_stall_sequencer
//   Stall/flush controller that sits beside the ID stage of the 5-stage pipeline.
//   Each cycle it decides the PC write enable, the IF/ID write enable and flush, and
//   the ID/EX bubble. It covers taken-branch squashes, load-use stalls and a fixed
//   latency multiply that holds the front end. It also keeps a saturating count of
//   the cycles in which the PC did not advance.
//
// Ports
//   clk             in   1      rising-edge clock
//   reset_n         in   1      asynchronous reset, active-low
//   id_ex_mem_read  in   1      ID/EX instruction is a load
//   id_ex_rt        in   REG_W  destination register of that load
//   if_id_rs        in   REG_W  Rs of the instruction in ID
//   if_id_rt        in   REG_W  Rt of the instruction in ID
//   if_id_uses_rt   in   1      ID instruction reads Rt
//   if_id_is_mul    in   1      ID instruction is a multiply
//   ex_branch_taken in   1      branch in EX resolved taken
//   perf_clr        in   1      synchronous clear of stall_cycles
//   pc_write        out  1      PC load enable                  (combinational)
//   if_id_write     out  1      IF/ID load enable               (combinational)
//   if_id_flush     out  1      IF/ID loads a NOP               (combinational)
//   id_ex_bubble    out  1      ID/EX loads a NOP               (combinational)
//   mul_start       out  1      multiply enters EX this cycle   (combinational)
//   mul_busy        out  1      multiply wait in progress       (combinational)
//   stall_cycles    out  CNT_W  saturating count of pc_write==0 cycles (registered)

module pipeline_stall_sequencer #(
    parameter int unsigned REG_W       = 3,
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned CNT_W       = 16,
    parameter bit          IGNORE_R0   = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             if_id_is_mul,
    input  logic             ex_branch_taken,
    input  logic             perf_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             mul_start,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned MCNT_W = 4;
    // Wait-counter load: the wait state lasts MUL_LATENCY-1 cycles
    localparam logic [MCNT_W-1:0] MCNT_LOAD = MCNT_W'(MUL_LATENCY - 1);
    localparam logic [MCNT_W-1:0] MCNT_ONE  = MCNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MUL_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MCNT_W-1:0]   r_mcnt;
    logic [MCNT_W-1:0]   w_mcnt_nxt;
    logic [CNT_W-1:0]    r_stall_cycles;

    logic                w_rt_is_r0;
    logic                w_src_match;
    logic                w_hazard;

    // Load-use detection against the instruction currently in ID
    always_comb begin
        w_rt_is_r0  = (id_ex_rt == '0);
        w_src_match = (id_ex_rt == if_id_rs) ||
                      (if_id_uses_rt && (id_ex_rt == if_id_rt));
        w_hazard    = id_ex_mem_read && !(IGNORE_R0 && w_rt_is_r0) && w_src_match;
    end

    // State register and multiply wait counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
            r_mcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mcnt  <= w_mcnt_nxt;
        end
    end

    // Next-state and pipeline control; reset forces a safe bubble-only pattern
    always_comb begin
        w_state_nxt  = r_state;
        w_mcnt_nxt   = r_mcnt;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        mul_start    = 1'b0;
        mul_busy     = 1'b0;

        if (!reset_n) begin
            w_state_nxt  = ST_RUN;
            w_mcnt_nxt   = '0;
            id_ex_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        // Squash both younger instructions; hazard and mul are moot
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (w_hazard) begin
                        // One-cycle stall: the bubble drops the load's mem_read
                        id_ex_bubble = 1'b1;
                    end else if (if_id_is_mul) begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        mul_start   = 1'b1;
                        w_state_nxt = ST_MUL_WAIT;
                        w_mcnt_nxt  = MCNT_LOAD;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end

                ST_MUL_WAIT: begin
                    // Front end frozen; EX holds only the multiply or bubbles
                    id_ex_bubble = 1'b1;
                    mul_busy     = 1'b1;
                    if (r_mcnt <= MCNT_ONE) begin
                        w_state_nxt = ST_RUN;
                        w_mcnt_nxt  = '0;
                    end else begin
                        w_mcnt_nxt  = r_mcnt - MCNT_ONE;
                    end
                end

                default: begin
                    w_state_nxt  = ST_RUN;
                    w_mcnt_nxt   = '0;
                    id_ex_bubble = 1'b1;
                end
            endcase
        end
    end

    // Saturating stall counter; clear wins over increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if (perf_clr) begin
            r_stall_cycles <= '0;
        end else if (!pc_write && (r_stall_cycles != CNT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + CNT_ONE;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Directed bench for pipeline_stall_sequencer (REG_W=3, MUL_LATENCY=4, CNT_W=4).
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units later.

module tb_pipeline_stall_sequencer;

    localparam int unsigned REG_W = 3;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic             id_ex_mem_read;
    logic [REG_W-1:0] id_ex_rt;
    logic [REG_W-1:0] if_id_rs;
    logic [REG_W-1:0] if_id_rt;
    logic             if_id_uses_rt;
    logic             if_id_is_mul;
    logic             ex_branch_taken;
    logic             perf_clr;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             mul_start;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_stall_sequencer #(
        .REG_W       (REG_W),
        .MUL_LATENCY (4),
        .CNT_W       (CNT_W),
        .IGNORE_R0   (1'b1)
    ) u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_rt        (id_ex_rt),
        .if_id_rs        (if_id_rs),
        .if_id_rt        (if_id_rt),
        .if_id_uses_rt   (if_id_uses_rt),
        .if_id_is_mul    (if_id_is_mul),
        .ex_branch_taken (ex_branch_taken),
        .perf_clr        (perf_clr),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .mul_start       (mul_start),
        .mul_busy        (mul_busy),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every control output against one expected pattern
    task automatic check_ctl(input string tag, input logic pc, input logic ifw,
                             input logic fl, input logic bub, input logic ms, input logic mb);
        check_eq({tag, ".pc_write"},     32'(pc_write),     32'(pc));
        check_eq({tag, ".if_id_write"},  32'(if_id_write),  32'(ifw));
        check_eq({tag, ".if_id_flush"},  32'(if_id_flush),  32'(fl));
        check_eq({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(bub));
        check_eq({tag, ".mul_start"},    32'(mul_start),    32'(ms));
        check_eq({tag, ".mul_busy"},     32'(mul_busy),     32'(mb));
    endtask

    task automatic check_cnt(input string tag, input int exp);
        check_eq({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_ex_mem_read  = 1'b0;
        id_ex_rt        = '0;
        if_id_rs        = '0;
        if_id_rt        = '0;
        if_id_uses_rt   = 1'b0;
        if_id_is_mul    = 1'b0;
        ex_branch_taken = 1'b0;
        perf_clr        = 1'b0;
    endtask

    task automatic clear_counter();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();

        // Reset state
        #3;
        check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_cnt("reset", 0);
        tick();
        check_cnt("reset_edge", 0);
        reset_n = 1'b1;
        #2;
        check_ctl("run_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Test 1: load-use on Rs, exactly one stall cycle
        tick();
        id_ex_mem_read = 1'b1; id_ex_rt = 3'd3; if_id_rs = 3'd3;
        #2;
        check_ctl("lu_rs", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        id_ex_mem_read = 1'b0;
        #2;
        check_ctl("lu_rs_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_cnt("lu_rs", 1);

        // Test 2: Rt compare gated by uses_rt, R0 ignored
        tick();
        id_ex_mem_read = 1'b1; id_ex_rt = 3'd5; if_id_rs = 3'd1; if_id_rt = 3'd5;
        if_id_uses_rt = 1'b0;
        #2;
        check_ctl("rt_unused", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_cnt("rt_unused", 1);
        if_id_uses_rt = 1'b1;
        #2;
        check_ctl("rt_used", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        idle_inputs();
        #2;
        check_cnt("rt_used", 2);
        id_ex_mem_read = 1'b1; id_ex_rt = 3'd0; if_id_rs = 3'd0;
        #1;
        check_ctl("r0_ignored", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_cnt("r0_ignored", 2);

        // Test 3: branch beats the load-use hazard
        id_ex_mem_read = 1'b1; id_ex_rt = 3'd3; if_id_rs = 3'd3; ex_branch_taken = 1'b1;
        if_id_is_mul = 1'b1;
        #2;
        check_ctl("branch", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle_inputs();
        #2;
        check_cnt("branch", 2);
        check_ctl("branch_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Test 4: multiply, MUL_LATENCY=4
        clear_counter();
        check_cnt("clr", 0);
        if_id_is_mul = 1'b1;
        #2;
        check_ctl("mul_T", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        if_id_is_mul = 1'b0;
        #2;
        check_ctl("mul_T1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        // Branch, hazard and a following multiply are all ignored while waiting
        if_id_is_mul = 1'b1; ex_branch_taken = 1'b1;
        id_ex_mem_read = 1'b1; id_ex_rt = 3'd2; if_id_rs = 3'd2;
        #2;
        check_ctl("mul_T2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        idle_inputs();
        #2;
        check_ctl("mul_T3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_cnt("mul_T3", 2);
        tick();
        #2;
        check_ctl("mul_T4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_cnt("mul_T4", 3);

        // Test 5: asynchronous reset in the middle of the multiply wait
        tick();
        clear_counter();
        if_id_is_mul = 1'b1;
        tick();
        if_id_is_mul = 1'b0;
        tick();
        #1;
        check_cnt("pre_reset", 1);
        check_eq("pre_reset.mul_busy", 32'(mul_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_ctl("mid_reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_cnt("mid_reset", 0);
        tick();
        reset_n = 1'b1;
        #2;
        check_ctl("post_reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_ctl("post_reset2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_cnt("post_reset2", 0);

        // Test 6: saturation at 15 and clear priority
        id_ex_mem_read = 1'b1; id_ex_rt = 3'd4; if_id_rs = 3'd4;
        for (int i = 0; i < 15; i++) tick();
        check_cnt("sat_15", 15);
        for (int i = 0; i < 5; i++) tick();
        check_cnt("sat_20", 15);
        perf_clr = 1'b1;
        #1;
        check_cnt("clr_before_edge", 15);
        tick();
        check_cnt("clr_priority", 0);
        idle_inputs();
        tick();
        check_cnt("after_clr", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
